// File: rtl/memory_stage_pkg.sv
// Shared types for the memory stage: control word, access size, FSM states
// and the byte-lane helpers used when a store or load is issued.
package memory_stage_pkg;
  localparam int unsigned RVGA_WORD = 32;
  typedef logic [RVGA_WORD-1:0] rvga_word_t;

  typedef enum logic [1:0] {MEM_BYTE, MEM_HALF, MEM_WORD} rvga_mem_size_e;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} rvga_mem_state_e;

  typedef struct packed {
    logic [4:0]     rd_addr;
    logic           rd_w_v;
    logic           br_v;
    logic           jmp_v;
    logic           ld_v;
    logic           st_v;
    rvga_mem_size_e mem_size;
    logic           ld_unsigned;
  } rvga_cword_t;

  function automatic logic [3:0] be_gen(rvga_mem_size_e size, logic [1:0] off);
    case (size)
      MEM_BYTE: return 4'b0001 << off;
      MEM_HALF: return 4'b0011 << {off[1], 1'b0};
      default:  return 4'b1111;
    endcase
  endfunction

  function automatic rvga_word_t wdata_gen(rvga_mem_size_e size, rvga_word_t rs2);
    case (size)
      MEM_BYTE: return {4{rs2[7:0]}};
      MEM_HALF: return {2{rs2[15:0]}};
      default:  return rs2;
    endcase
  endfunction

  function automatic logic misaligned(rvga_mem_size_e size, logic [1:0] off);
    case (size)
      MEM_HALF: return off[0];
      MEM_WORD: return off != 2'b00;
      default:  return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/memory_stage_if.sv
// Data-memory port: req/gnt request phase, rvalid/rdata response phase.
interface memory_stage_if;
  logic        req_v;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req_v, we, addr, wdata, be, input gnt, rvalid, rdata);
  modport slave  (input req_v, we, addr, wdata, be, output gnt, rvalid, rdata);
endinterface

// File: rtl/memory_stage_load_align.sv
// Combinational load lane select and sign/zero extension; kept standalone so
// a cache fill path can reuse it.
module memory_stage_load_align
  import memory_stage_pkg::*;
(
  input  rvga_word_t     rdata_i,
  input  logic [1:0]     off_i,
  input  rvga_mem_size_e size_i,
  input  logic           unsigned_i,
  output rvga_word_t     data_o
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b      = rdata_i[8*off_i +: 8];
    h      = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    data_o = rdata_i;
    case (size_i)
      MEM_BYTE: data_o = unsigned_i ? {24'b0, b} : {{24{b[7]}}, b};
      MEM_HALF: data_o = unsigned_i ? {16'b0, h} : {{16{h[15]}}, h};
      default:  data_o = rdata_i;
    endcase
  end
endmodule

// File: rtl/memory_stage.sv
// Pipeline stage between execute and writeback: registers results and runs
// loads/stores over the req/gnt/rvalid port, stalling execute meanwhile.
module memory_stage
  import memory_stage_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             instr_v_i,
  input  rvga_cword_t      cword_i,
  input  rvga_word_t       alu_result_i,
  input  rvga_word_t       rs2_data_i,
  input  logic             btaken_i,
  input  logic             stall_v_i,
  output logic             stall_v_o,
  memory_stage_if.master   dmem,
  output logic             instr_v_o,
  output rvga_cword_t      cword_o,
  output rvga_word_t       alu_or_ld_result_o,
  output logic             btaken_o,
  output logic             misalign_v_o
);
  rvga_mem_state_e state_q, state_d;
  rvga_cword_t     hcw_q, hcw_d, cw_q, cw_d;
  rvga_word_t      haddr_q, haddr_d, hwdata_q, hwdata_d, hres_q, hres_d, res_q, res_d;
  logic [3:0]      hbe_q, hbe_d;
  logic            hbt_q, hbt_d, vld_q, vld_d, bt_q, bt_d, mis_q, mis_d;
  logic            is_mem, misal, done;
  rvga_word_t      ld_data;

  memory_stage_load_align u_align (
    .rdata_i    (dmem.rdata),
    .off_i      (haddr_q[1:0]),
    .size_i     (hcw_q.mem_size),
    .unsigned_i (hcw_q.ld_unsigned),
    .data_o     (ld_data)
  );

  assign is_mem = cword_i.ld_v | cword_i.st_v;
  assign misal  = misaligned(cword_i.mem_size, alu_result_i[1:0]);

  always_comb begin
    state_d  = state_q;
    hcw_d    = hcw_q;
    haddr_d  = haddr_q;
    hwdata_d = hwdata_q;
    hbe_d    = hbe_q;
    hbt_d    = hbt_q;
    hres_d   = hres_q;
    vld_d    = vld_q;
    cw_d     = cw_q;
    res_d    = res_q;
    bt_d     = bt_q;
    mis_d    = 1'b0;
    done     = 1'b0;
    // Any unstalled cycle that delivers nothing pushes a bubble downstream.
    if (!stall_v_i) vld_d = 1'b0;
    case (state_q)
      ST_IDLE: if (!stall_v_i && instr_v_i) begin
        if (is_mem && !misal) begin
          hcw_d    = cword_i;
          haddr_d  = alu_result_i;
          hwdata_d = wdata_gen(cword_i.mem_size, rs2_data_i);
          hbe_d    = be_gen(cword_i.mem_size, alu_result_i[1:0]);
          hbt_d    = btaken_i;
          state_d  = ST_REQ;
        end else begin
          // Misaligned accesses retire as no-ops with the register write suppressed.
          vld_d = 1'b1;
          cw_d  = cword_i;
          res_d = alu_result_i;
          bt_d  = btaken_i;
          if (is_mem) begin
            cw_d.rd_w_v = 1'b0;
            mis_d       = 1'b1;
          end
        end
      end
      ST_REQ: if (dmem.gnt) begin
        if (hcw_q.st_v) begin
          hres_d = haddr_q;
          done   = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: if (dmem.rvalid) begin
        hres_d = ld_data;
        done   = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: state_d = ST_IDLE;
    endcase
    if (done) begin
      if (!stall_v_i) begin
        vld_d   = 1'b1;
        cw_d    = hcw_q;
        res_d   = hres_d;
        bt_d    = hbt_q;
        state_d = ST_IDLE;
      end else begin
        state_d = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      hcw_q    <= '0;
      haddr_q  <= '0;
      hwdata_q <= '0;
      hbe_q    <= '0;
      hbt_q    <= 1'b0;
      hres_q   <= '0;
      vld_q    <= 1'b0;
      cw_q     <= '0;
      res_q    <= '0;
      bt_q     <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hcw_q    <= hcw_d;
      haddr_q  <= haddr_d;
      hwdata_q <= hwdata_d;
      hbe_q    <= hbe_d;
      hbt_q    <= hbt_d;
      hres_q   <= hres_d;
      vld_q    <= vld_d;
      cw_q     <= cw_d;
      res_q    <= res_d;
      bt_q     <= bt_d;
      mis_q    <= mis_d;
    end
  end

  assign stall_v_o          = (state_q != ST_IDLE) || stall_v_i;
  assign dmem.req_v         = (state_q == ST_REQ);
  assign dmem.we            = hcw_q.st_v;
  assign dmem.addr          = haddr_q;
  assign dmem.wdata         = hwdata_q;
  assign dmem.be            = hbe_q;
  assign instr_v_o          = vld_q;
  assign cword_o            = cw_q;
  assign alu_or_ld_result_o = res_q;
  assign btaken_o           = bt_q;
  assign misalign_v_o       = mis_q;
endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: expected deliveries are queued when an
// instruction is driven and popped when the stage presents it.
module tb_memory_stage;
  import memory_stage_pkg::*;

  typedef struct packed {
    rvga_cword_t cw;
    logic [31:0] res;
    logic        bt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_v_i = 1'b0;
  rvga_cword_t cword_i = '0;
  logic [31:0] alu_result_i = '0;
  logic [31:0] rs2_data_i = '0;
  logic        btaken_i = 1'b0;
  logic        stall_v_i = 1'b0;
  logic        stall_v_o, instr_v_o, btaken_o, misalign_v_o;
  rvga_cword_t cword_o;
  logic [31:0] result_o;

  int   pass_cnt = 0;
  int   total_cnt = 0;
  exp_t sb[$];

  memory_stage_if dmem ();

  always #5 clk = ~clk;

  memory_stage dut (
    .clk_i              (clk),
    .rst_i              (rst_n),
    .instr_v_i          (instr_v_i),
    .cword_i            (cword_i),
    .alu_result_i       (alu_result_i),
    .rs2_data_i         (rs2_data_i),
    .btaken_i           (btaken_i),
    .stall_v_i          (stall_v_i),
    .stall_v_o          (stall_v_o),
    .dmem               (dmem.master),
    .instr_v_o          (instr_v_o),
    .cword_o            (cword_o),
    .alu_or_ld_result_o (result_o),
    .btaken_o           (btaken_o),
    .misalign_v_o       (misalign_v_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt = total_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic rvga_cword_t mkcw(logic ld, logic st, rvga_mem_size_e sz, logic uns,
                                       logic [4:0] rd, logic br);
    rvga_cword_t c;
    c             = '0;
    c.rd_addr     = rd;
    c.rd_w_v      = ld | ~st;
    c.br_v        = br;
    c.ld_v        = ld;
    c.st_v        = st;
    c.mem_size    = sz;
    c.ld_unsigned = uns;
    return c;
  endfunction

  // Drive one instruction for a single cycle; its expected delivery is queued.
  task automatic issue(input rvga_cword_t cw, input logic [31:0] alu, input logic [31:0] rs2,
                       input logic bt, input exp_t e);
    cword_i      = cw;
    alu_result_i = alu;
    rs2_data_i   = rs2;
    btaken_i     = bt;
    instr_v_i    = 1'b1;
    sb.push_back(e);
    tick();
    instr_v_i = 1'b0;
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    chk({tag, "_vld"}, 32'(instr_v_o), 32'd1);
    chk({tag, "_sb_has_entry"}, 32'(sb.size() != 0), 32'd1);
    e = '1;
    if (sb.size() != 0) e = sb.pop_front();
    chk({tag, "_cword"}, 32'(cword_o), 32'(e.cw));
    chk({tag, "_result"}, result_o, e.res);
    chk({tag, "_btaken"}, 32'(btaken_o), 32'(e.bt));
  endtask

  initial begin
    rvga_cword_t c;
    dmem.gnt    = 1'b0;
    dmem.rvalid = 1'b0;
    dmem.rdata  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", 32'(instr_v_o), 32'd0);
    chk("rst_btaken", 32'(btaken_o), 32'd0);
    chk("rst_req", 32'(dmem.req_v), 32'd0);
    chk("rst_misalign", 32'(misalign_v_o), 32'd0);
    chk("rst_cword", 32'(cword_o), 32'd0);
    chk("rst_result", result_o, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: non-mem op, single-cycle latency, never stalls execute
    c = mkcw(1'b0, 1'b0, MEM_WORD, 1'b0, 5'd5, 1'b1);
    chk("t1_stall_pre", 32'(stall_v_o), 32'd0);
    issue(c, 32'h1234, 32'h0, 1'b1, '{cw: c, res: 32'h1234, bt: 1'b1});
    check_out("t1");
    chk("t1_stall_post", 32'(stall_v_o), 32'd0);
    tick();
    chk("t1_bubble", 32'(instr_v_o), 32'd0);

    // 2: SB to byte 3 with gnt two cycles late
    c = mkcw(1'b0, 1'b1, MEM_BYTE, 1'b0, 5'd0, 1'b0);
    chk("t2_stall_accept", 32'(stall_v_o), 32'd0);
    issue(c, 32'h103, 32'hAB, 1'b0, '{cw: c, res: 32'h103, bt: 1'b0});
    chk("t2_be", 32'(dmem.be), 32'h8);
    chk("t2_wdata", dmem.wdata, 32'hABABABAB);
    chk("t2_addr", dmem.addr, 32'h103);
    chk("t2_we", 32'(dmem.we), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("t2_req_held", 32'(dmem.req_v), 32'd1);
      chk("t2_stall_hi", 32'(stall_v_o), 32'd1);
      chk("t2_no_out", 32'(instr_v_o), 32'd0);
      if (i == 2) dmem.gnt = 1'b1;
      tick();
    end
    dmem.gnt = 1'b0;
    check_out("t2");
    chk("t2_req_drop", 32'(dmem.req_v), 32'd0);
    chk("t2_stall_lo", 32'(stall_v_o), 32'd0);

    // 3: LH / LHU from the upper half, rvalid one cycle after gnt
    for (int u = 0; u < 2; u++) begin
      c = mkcw(1'b1, 1'b0, MEM_HALF, u[0], 5'd7, 1'b0);
      issue(c, 32'h102, 32'h0, 1'b0,
            '{cw: c, res: (u == 0) ? 32'hFFFF8001 : 32'h00008001, bt: 1'b0});
      chk("t3_be", 32'(dmem.be), 32'hC);
      chk("t3_we", 32'(dmem.we), 32'd0);
      dmem.gnt = 1'b1;
      tick();
      dmem.gnt    = 1'b0;
      chk("t3_req_wait", 32'(dmem.req_v), 32'd0);
      dmem.rvalid = 1'b1;
      dmem.rdata  = 32'h8001_0000;
      tick();
      dmem.rvalid = 1'b0;
      check_out(u == 0 ? "t3_lh" : "t3_lhu");
    end

    // 4: LW completes under a 3-cycle downstream stall
    c = mkcw(1'b1, 1'b0, MEM_WORD, 1'b0, 5'd9, 1'b0);
    issue(c, 32'h200, 32'h0, 1'b1, '{cw: c, res: 32'hDEADBEEF, bt: 1'b1});
    dmem.gnt = 1'b1;
    tick();
    dmem.gnt    = 1'b0;
    dmem.rvalid = 1'b1;
    dmem.rdata  = 32'hDEADBEEF;
    stall_v_i   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      dmem.rvalid = 1'b0;
      chk("t4_frozen_vld", 32'(instr_v_o), 32'd0);
      chk("t4_stall_o", 32'(stall_v_o), 32'd1);
      chk("t4_no_req", 32'(dmem.req_v), 32'd0);
    end
    stall_v_i = 1'b0;
    tick();
    check_out("t4");
    stall_v_i = 1'b1;
    tick();
    chk("t4_hold_vld", 32'(instr_v_o), 32'd1);
    chk("t4_hold_result", result_o, 32'hDEADBEEF);
    stall_v_i = 1'b0;
    tick();
    chk("t4_bubble", 32'(instr_v_o), 32'd0);

    // 5: misaligned LW is dropped and flagged
    c = mkcw(1'b1, 1'b0, MEM_WORD, 1'b0, 5'd3, 1'b0);
    chk("t5_mis_pre", 32'(misalign_v_o), 32'd0);
    begin
      rvga_cword_t ce;
      ce        = c;
      ce.rd_w_v = 1'b0;
      issue(c, 32'h101, 32'h0, 1'b0, '{cw: ce, res: 32'h101, bt: 1'b0});
    end
    chk("t5_no_req", 32'(dmem.req_v), 32'd0);
    chk("t5_mis_pulse", 32'(misalign_v_o), 32'd1);
    chk("t5_rd_w_v", 32'(cword_o.rd_w_v), 32'd0);
    check_out("t5");
    tick();
    chk("t5_mis_once", 32'(misalign_v_o), 32'd0);
    chk("t5_no_req2", 32'(dmem.req_v), 32'd0);

    // 6: reset while waiting for load data, then a late rvalid
    c = mkcw(1'b1, 1'b0, MEM_WORD, 1'b0, 5'd4, 1'b0);
    cword_i = c; alu_result_i = 32'h300; instr_v_i = 1'b1;
    tick();
    instr_v_i = 1'b0;
    dmem.gnt  = 1'b1;
    tick();
    dmem.gnt = 1'b0;
    chk("t6_wait_stall", 32'(stall_v_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_vld", 32'(instr_v_o), 32'd0);
    chk("t6_rst_stall", 32'(stall_v_o), 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    dmem.rvalid = 1'b1;
    dmem.rdata  = 32'h1234_5678;
    tick();
    dmem.rvalid = 1'b0;
    chk("t6_late_rvalid", 32'(instr_v_o), 32'd0);
    chk("t6_no_req", 32'(dmem.req_v), 32'd0);
    c = mkcw(1'b0, 1'b0, MEM_WORD, 1'b0, 5'd6, 1'b0);
    issue(c, 32'h55, 32'h0, 1'b0, '{cw: c, res: 32'h55, bt: 1'b0});
    check_out("t6_next");

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
